// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for NB = 4, 6 or 8 columns, STAGES register stages.
// Optional per-beat bypass (in_byp / out_byp) is enabled by defining SHIFT_ROWS_BYPASS_EN.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [32*NB-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data,
  output logic             out_inv
`ifdef SHIFT_ROWS_BYPASS_EN
  ,
  input  logic             in_byp,
  output logic             out_byp
`endif
);
  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be in 1..4");
  end

  // Rijndael row offsets; the wide block uses a larger spread for rows 2 and 3.
  function automatic int row_shift(input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      3:       return (NB == 8) ? 4 : 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] permute(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] o;
    int           src_f;
    int           src_i;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        src_f = (c + row_shift(r)) % NB;
        src_i = (c - row_shift(r) + NB) % NB;
        o[W-1-32*c-8*r -: 8] = inv ? d[W-1-32*src_i-8*r -: 8] : d[W-1-32*src_f-8*r -: 8];
      end
    end
    return o;
  endfunction

  logic [STAGES-1:0]        v_q;
  logic [STAGES-1:0]        v_d;
  logic [STAGES-1:0]        inv_q;
  logic [STAGES-1:0]        inv_d;
  logic [STAGES-1:0][W-1:0] data_q;
  logic [STAGES-1:0][W-1:0] data_d;
  logic [STAGES-1:0]        load_s;
  logic [STAGES-1:0]        src_v_s;
  logic [STAGES-1:0]        src_inv_s;
  logic [STAGES-1:0][W-1:0] src_data_s;
  logic [W-1:0]             stage_in_s;

`ifdef SHIFT_ROWS_BYPASS_EN
  assign stage_in_s = in_byp ? in_data : permute(in_data, in_inv);
`else
  assign stage_in_s = permute(in_data, in_inv);
`endif

  assign src_v_s[0]    = in_valid;
  assign src_inv_s[0]  = in_inv;
  assign src_data_s[0] = stage_in_s;
  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign src_v_s[k]    = v_q[k-1];
    assign src_inv_s[k]  = inv_q[k-1];
    assign src_data_s[k] = data_q[k-1];
  end

  // Ready chain from the tail: a stage loads when empty or when the stage after it loads.
  always_comb begin
    logic acc;
    acc    = out_ready;
    load_s = {STAGES{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc       = ~v_q[k] | acc;
      load_s[k] = acc;
    end
  end

  assign in_ready = load_s[0];

  // Next-state: payload changes only when a valid beat actually moves in.
  always_comb begin
    v_d    = v_q;
    inv_d  = inv_q;
    data_d = data_q;
    for (int k = 0; k < STAGES; k++) begin
      if (load_s[k] && src_v_s[k]) begin
        v_d[k]    = 1'b1;
        inv_d[k]  = src_inv_s[k];
        data_d[k] = src_data_s[k];
      end else if (load_s[k]) begin
        v_d[k] = 1'b0;
      end else begin
        v_d[k] = v_q[k];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= {STAGES{1'b0}};
      inv_q  <= {STAGES{1'b0}};
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      inv_q  <= inv_d;
      data_q <= data_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_inv   = inv_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

`ifdef SHIFT_ROWS_BYPASS_EN
  logic [STAGES-1:0] byp_q;
  logic [STAGES-1:0] byp_d;
  logic [STAGES-1:0] src_byp_s;

  assign src_byp_s[0] = in_byp;
  for (genvar k = 1; k < STAGES; k++) begin : g_byp_link
    assign src_byp_s[k] = byp_q[k-1];
  end

  // Bypass flag travels with its beat exactly like the direction flag.
  always_comb begin
    byp_d = byp_q;
    for (int k = 0; k < STAGES; k++) begin
      if (load_s[k] && src_v_s[k]) begin
        byp_d[k] = src_byp_s[k];
      end else begin
        byp_d[k] = byp_q[k];
      end
    end
  end

  // Bypass flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= {STAGES{1'b0}};
    end else begin
      byp_q <= byp_d;
    end
  end

  assign out_byp = byp_q[STAGES-1];
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: three instances (NB4/S1, NB4/S3, NB8/S2) checked
// against a row-rotation queue model plus known-answer vectors.
module tb_shift_rows_pipe;
  logic clk;
  logic rst_n;

  logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
  logic [127:0] a_in_data, a_out_data;
  logic         a_in_byp, a_out_byp;
  logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
  logic [127:0] b_in_data, b_out_data;
  logic         b_in_byp, b_out_byp;
  logic         c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_out_inv;
  logic [255:0] c_in_data, c_out_data;
  logic         c_in_byp, c_out_byp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [257:0] exp_q [3][$];
  logic         stall_q [3];
  logic [257:0] held_q [3];
  int           n_out [3];

  shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_inv(a_out_inv)
`ifdef SHIFT_ROWS_BYPASS_EN
    , .in_byp(a_in_byp), .out_byp(a_out_byp)
`endif
  );

  shift_rows_pipe #(.NB(4), .STAGES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_inv(b_out_inv)
`ifdef SHIFT_ROWS_BYPASS_EN
    , .in_byp(b_in_byp), .out_byp(b_out_byp)
`endif
  );

  shift_rows_pipe #(.NB(8), .STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_inv(c_out_inv)
`ifdef SHIFT_ROWS_BYPASS_EN
    , .in_byp(c_in_byp), .out_byp(c_out_byp)
`endif
  );

`ifndef SHIFT_ROWS_BYPASS_EN
  assign a_out_byp = 1'b0;
  assign b_out_byp = 1'b0;
  assign c_out_byp = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each row as a byte queue, rotated left (forward) or right (inverse) by its offset.
  function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d, input logic inv);
    logic [7:0]   st [4][8];
    logic [7:0]   row [$];
    logic [255:0] o;
    int           sh;
    o = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[32*nb-1-32*c-8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      row = {};
      for (int c = 0; c < nb; c++) row.push_back(st[r][c]);
      sh = (r < 2) ? r : ((nb == 8) ? r + 1 : r);
      repeat (sh) begin
        if (!inv) row.push_back(row.pop_front());
        else      row.push_front(row.pop_back());
      end
      for (int c = 0; c < nb; c++) o[32*nb-1-32*c-8*r -: 8] = row[c];
    end
    return o;
  endfunction

  task automatic mon_step(input int id, input int nb, input logic iv, input logic ir,
                          input logic [255:0] idat, input logic iinv, input logic ibyp,
                          input logic ov, input logic ordy, input logic [255:0] odat,
                          input logic oinv, input logic obyp);
    logic [257:0] obs;
    logic [257:0] exp;
    obs = {obyp, oinv, odat};
    if (stall_q[id]) begin
      check_val("stall_valid", {259'd0, ov}, 260'd1);
      check_val("stall_hold", {2'b00, obs}, {2'b00, held_q[id]});
    end
    if (ov && ordy) begin
      if (exp_q[id].size() == 0) begin
        check_val("no_extra_beat", {259'd0, ov}, 260'd0);
      end else begin
        exp = exp_q[id].pop_front();
        check_val("beat", {2'b00, obs}, {2'b00, exp});
        n_out[id]++;
      end
    end
    if (iv && ir)
      exp_q[id].push_back({ibyp, iinv, ibyp ? idat : ref_perm(nb, idat, iinv)});
    stall_q[id] = ov && !ordy;
    held_q[id]  = obs;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_q[i].delete();
        stall_q[i] = 1'b0;
      end
    end else begin
      mon_step(0, 4, a_in_valid, a_in_ready, {128'd0, a_in_data}, a_in_inv, a_in_byp,
               a_out_valid, a_out_ready, {128'd0, a_out_data}, a_out_inv, a_out_byp);
      mon_step(1, 4, b_in_valid, b_in_ready, {128'd0, b_in_data}, b_in_inv, b_in_byp,
               b_out_valid, b_out_ready, {128'd0, b_out_data}, b_out_inv, b_out_byp);
      mon_step(2, 8, c_in_valid, c_in_ready, c_in_data, c_in_inv, c_in_byp,
               c_out_valid, c_out_ready, c_out_data, c_out_inv, c_out_byp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] k1_in, k1_out, k2_in, k2_inv, k2_fwd, rnd;
    logic [255:0] k5_in, k5_fwd;
    int sent, guard, acc, seen;

    k1_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
    k1_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    k2_in  = 128'h000102030405060708090a0b0c0d0e0f;
    k2_inv = 128'h000d0a0704010e0b0805020f0c090603;
    k2_fwd = 128'h00050a0f04090e03080d02070c01060b;
    k5_in  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    k5_fwd = 256'h00050e13040912170_80d161b0c111a1f10151e0314190207181d060b1c010a0f;
    for (int i = 0; i < 3; i++) begin
      stall_q[i] = 1'b0;
      n_out[i]   = 0;
    end

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_data = '0; a_out_ready = 1'b1; a_in_byp = 1'b0;
    b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_in_byp = 1'b0;
    c_in_valid = 1'b0; c_in_inv = 1'b0; c_in_data = '0; c_out_ready = 1'b1; c_in_byp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check_val("rst_a_ready", {259'd0, a_in_ready}, 260'd1);
    check_val("rst_a_valid", {259'd0, a_out_valid}, 260'd0);
    check_val("rst_a_data", {132'd0, a_out_data}, 260'd0);
    check_val("rst_a_inv", {259'd0, a_out_inv}, 260'd0);
    check_val("rst_b_ready", {259'd0, b_in_ready}, 260'd1);
    check_val("rst_c_state", {2'b00, c_out_valid, c_out_inv, c_out_data}, 260'd0);

    // Known answers, one-cycle latency, mode change every beat.
    tick();
    a_in_valid = 1'b1; a_in_data = k1_in; a_in_inv = 1'b0;
    tick();
    a_in_data = k2_in; a_in_inv = 1'b1;
    @(negedge clk);
    check_val("t1_valid", {259'd0, a_out_valid}, 260'd1);
    check_val("t1_data", {132'd0, a_out_data}, {132'd0, k1_out});
    check_val("t1_inv", {259'd0, a_out_inv}, 260'd0);
    tick();
    a_in_data = k2_in; a_in_inv = 1'b0;
    @(negedge clk);
    check_val("t2_inv_data", {132'd0, a_out_data}, {132'd0, k2_inv});
    check_val("t2_inv_flag", {259'd0, a_out_inv}, 260'd1);
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    check_val("t2_fwd_data", {132'd0, a_out_data}, {132'd0, k2_fwd});
    tick();
    @(negedge clk);
    check_val("t2_empty", {259'd0, a_out_valid}, 260'd0);

    // Random beats through 3 stages with random backpressure.
    sent = 0;
    guard = 0;
    while (sent < 20 && guard < 600) begin
      tick();
      rnd = {$urandom, $urandom, $urandom, $urandom};
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = rnd;
      b_in_inv    = (sent % 2 == 1);
      b_out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (b_in_valid && b_in_ready) sent++;
      guard++;
    end
    check_val("t3_sent", sent, 20);
    tick();
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    guard = 0;
    while (exp_q[1].size() != 0 && guard < 60) begin
      tick();
      guard++;
    end
    check_val("t3_drain", exp_q[1].size(), 0);
    check_val("t3_count", n_out[1], 20);

    // Full-pipeline stall on the 2-stage wide instance, then full throughput.
    acc = 0;
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_in_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      c_in_inv  = $urandom_range(0, 1);
      @(negedge clk);
      if (c_in_ready) acc++;
      tick();
    end
    check_val("t4_accepts", acc, 2);
    c_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_in_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      c_in_inv  = $urandom_range(0, 1);
      @(negedge clk);
      check_val("t4_out_valid", {259'd0, c_out_valid}, 260'd1);
      check_val("t4_in_ready", {259'd0, c_in_ready}, 260'd1);
      tick();
    end
    c_in_valid = 1'b0;
    repeat (4) tick();
    check_val("t4_drain", exp_q[2].size(), 0);

    // NB=8 rotation offsets {0,1,3,4} and inverse round trip.
    c_in_valid = 1'b1; c_in_data = k5_in; c_in_inv = 1'b0;
    tick();
    c_in_valid = 1'b0;
    @(negedge clk);
    check_val("t5_latency", {259'd0, c_out_valid}, 260'd0);
    tick();
    @(negedge clk);
    check_val("t5_fwd_valid", {259'd0, c_out_valid}, 260'd1);
    check_val("t5_fwd", {4'd0, c_out_data}, {4'd0, k5_fwd});
    tick();
    c_in_valid = 1'b1; c_in_data = k5_fwd; c_in_inv = 1'b1;
    tick();
    c_in_valid = 1'b0;
    tick();
    @(negedge clk);
    check_val("t5_inv", {4'd0, c_out_data}, {4'd0, k5_in});
    check_val("t5_inv_flag", {259'd0, c_out_inv}, 260'd1);
    tick();

`ifdef SHIFT_ROWS_BYPASS_EN
    // Bypass beat passes unpermuted.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    a_in_valid = 1'b1; a_in_data = rnd; a_in_inv = 1'b1; a_in_byp = 1'b1;
    tick();
    a_in_valid = 1'b0; a_in_byp = 1'b0;
    @(negedge clk);
    check_val("byp_data", {132'd0, a_out_data}, {132'd0, rnd});
    check_val("byp_flag", {259'd0, a_out_byp}, 260'd1);
    tick();
`endif

    // Reset with three beats in flight.
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_in_data = {$urandom, $urandom, $urandom, $urandom};
      b_in_inv  = $urandom_range(0, 1);
      tick();
    end
    b_in_valid = 1'b0;
    check_val("t6_inflight", {259'd0, b_out_valid}, 260'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_async_valid", {259'd0, b_out_valid}, 260'd0);
    check_val("t6_async_data", {131'd0, b_out_inv, b_out_data}, 260'd0);
    check_val("t6_ready", {259'd0, b_in_ready}, 260'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b_out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_out_valid) seen++;
    end
    check_val("t6_silent", seen, 0);

    for (int i = 0; i < 3; i++) check_val("q_empty", exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
